// File: rtl/rv32_pkg.sv
// rv32_pkg: constants shared by the RV32 immediate encoder and decoder.
//   - format vector bit indices: {is_r, is_i, is_s, is_s_subtype_b, is_u, is_u_subtype_j}
//   - the six legal one-/two-hot format codes
//   - instruction field widths
package rv32_pkg;

   localparam int XLEN  = 32;
   localparam int FMT_W = 6;
   localparam int OPC_W = 7;
   localparam int REG_W = 5;
   localparam int F3_W  = 3;
   localparam int F7_W  = 7;

   // Bit positions inside the format vector
   localparam int FMT_R_IDX  = 5;
   localparam int FMT_I_IDX  = 4;
   localparam int FMT_S_IDX  = 3;
   localparam int FMT_SB_IDX = 2;
   localparam int FMT_U_IDX  = 1;
   localparam int FMT_UJ_IDX = 0;

   // B and J are subtypes: they keep the parent bit set alongside their own
   localparam logic [FMT_W-1:0] FMT_R = 6'b100000;
   localparam logic [FMT_W-1:0] FMT_I = 6'b010000;
   localparam logic [FMT_W-1:0] FMT_S = 6'b001000;
   localparam logic [FMT_W-1:0] FMT_B = 6'b001100;
   localparam logic [FMT_W-1:0] FMT_U = 6'b000010;
   localparam logic [FMT_W-1:0] FMT_J = 6'b000011;

   // Payload carried through both pipeline stages
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic            err;
   } enc_word_t;

endpackage

// File: rtl/rv32_mod_imm_range_check.sv
// rv32_mod_imm_range_check: combinational legality check of a format code and
// whether the immediate fits the field the format scatters it into.
// Ports:
//   i_format       format vector
//   i_immediate    unscattered immediate
//   o_in_range     immediate representable (always 1 unless range checking built in)
//   o_format_legal format is one of R/I/S/B/U/J
// Build option: RV32_IMM_ENC_RANGE_CHECK_EN compiles in the range rules.
module rv32_mod_imm_range_check
   import rv32_pkg::*;
(
   input  logic [FMT_W-1:0] i_format,
   input  logic [XLEN-1:0]  i_immediate,
   output logic             o_in_range,
   output logic             o_format_legal
);

   assign o_format_legal = i_format inside {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J};

`ifdef RV32_IMM_ENC_RANGE_CHECK_EN
   // "All equal" = sign extension of the highest encoded bit is intact
   logic w_hi11_eq, w_hi12_eq, w_hi20_eq;
   assign w_hi11_eq = (&i_immediate[31:11]) | ~(|i_immediate[31:11]);
   assign w_hi12_eq = (&i_immediate[31:12]) | ~(|i_immediate[31:12]);
   assign w_hi20_eq = (&i_immediate[31:20]) | ~(|i_immediate[31:20]);

   always_comb begin
      o_in_range = 1'b1;
      case (i_format)
         FMT_I, FMT_S: o_in_range = w_hi11_eq;
         FMT_B:        o_in_range = w_hi12_eq & ~i_immediate[0];
         FMT_J:        o_in_range = w_hi20_eq & ~i_immediate[0];
         FMT_U:        o_in_range = ~(|i_immediate[11:0]);
         default:      o_in_range = 1'b1;
      endcase
   end
`else
   logic w_unused_imm;
   assign w_unused_imm = ^i_immediate;
   assign o_in_range   = 1'b1;
`endif

endmodule

// File: rtl/rv32_mod_instruction_encoder_imm.sv
// rv32_mod_instruction_encoder_imm: two-stage valid/ready RV32 encoder.
// Packs opcode/register/funct fields and scatters the immediate per format.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake; in_ready = s1 can load
//   in_format .. in_immediate  instruction fields
//   out_valid/out_ready output handshake
//   out_instruction     encoded word (0 for an illegal format)
//   out_error           illegal format, or immediate out of range when checked
//   err_sticky          set by any transferred error, cleared by err_clear (set wins)
// Build option: RV32_IMM_ENC_RANGE_CHECK_EN adds range violations to out_error.
module rv32_mod_instruction_encoder_imm
   import rv32_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FMT_W-1:0] in_format,
   input  logic [OPC_W-1:0] in_opcode,
   input  logic [REG_W-1:0] in_rd,
   input  logic [REG_W-1:0] in_rs1,
   input  logic [REG_W-1:0] in_rs2,
   input  logic [F3_W-1:0]  in_funct3,
   input  logic [F7_W-1:0]  in_funct7,
   input  logic [XLEN-1:0]  in_immediate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_instruction,
   output logic             out_error,
   output logic             err_sticky,
   input  logic             err_clear
);

   logic            w_in_range, w_fmt_legal;
   logic            w_s1_load, w_s2_load;
   enc_word_t       w_enc;
   logic [XLEN-1:0] w_imm;

   logic            r_s1_valid, r_s2_valid, r_err_sticky;
   enc_word_t       r_s1, r_s2;

   rv32_mod_imm_range_check u_range (
      .i_format       (in_format),
      .i_immediate    (in_immediate),
      .o_in_range     (w_in_range),
      .o_format_legal (w_fmt_legal)
   );

   assign w_imm = in_immediate;

   // Immediate scatter; imm[0] of B/J is dropped (caught by the range check)
   always_comb begin
      w_enc.instr = '0;
      case (in_format)
         FMT_R: w_enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: w_enc.instr = {w_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S: w_enc.instr = {w_imm[11:5], in_rs2, in_rs1, in_funct3, w_imm[4:0], in_opcode};
         FMT_B: w_enc.instr = {w_imm[12], w_imm[10:5], in_rs2, in_rs1, in_funct3,
                               w_imm[4:1], w_imm[11], in_opcode};
         FMT_U: w_enc.instr = {w_imm[31:12], in_rd, in_opcode};
         FMT_J: w_enc.instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                               in_rd, in_opcode};
         default: w_enc.instr = '0;
      endcase
      w_enc.err = ~w_fmt_legal | ~w_in_range;
   end

   // Skid-free two-stage pipe: each stage loads when it is empty or draining
   assign w_s2_load = ~r_s2_valid | out_ready;
   assign w_s1_load = ~r_s1_valid | w_s2_load;
   assign in_ready  = w_s1_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s1         <= '0;
         r_s2         <= '0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1 <= w_enc;
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2 <= r_s1;
         end
         if (r_s2_valid && out_ready && r_s2.err) r_err_sticky <= 1'b1;
         else if (err_clear)                      r_err_sticky <= 1'b0;
      end
   end

   assign out_valid       = r_s2_valid;
   assign out_instruction = r_s2.instr;
   assign out_error       = r_s2.err;
   assign err_sticky      = r_err_sticky;

endmodule

// File: tb/tb_rv32_mod_instruction_encoder_imm.sv
// Bench for rv32_mod_instruction_encoder_imm: table of hand-encoded vectors
// checked through an in-order scoreboard, plus backpressure, sticky-error,
// latency and asynchronous-reset sequences.
module tb_rv32_mod_instruction_encoder_imm;

`ifdef RV32_IMM_ENC_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   localparam logic [5:0] F_R = 6'b100000, F_I = 6'b010000, F_S = 6'b001000,
                          F_B = 6'b001100, F_U = 6'b000010, F_J = 6'b000011;

   typedef struct {
      logic [5:0]  fmt;
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp;
      bit          ferr;
      bit          rerr;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      bit          err;
   } sb_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [5:0]  in_format = '0;
   logic [6:0]  in_opcode = '0, in_funct7 = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_immediate = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] out_instruction;
   logic        out_error, err_sticky, err_clear = 1'b0;

   int checks = 0, failures = 0;
   sb_t q[$];
   sb_t cur_exp, popped;
   vec_t tbl[18];

   rv32_mod_instruction_encoder_imm dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_format(in_format), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_immediate(in_immediate),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instruction(out_instruction), .out_error(out_error),
      .err_sticky(err_sticky), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [5:0] fmt, logic [6:0] opc, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                               logic [6:0] f7, logic [31:0] imm, logic [31:0] exp,
                               bit ferr, bit rerr);
      vec_t v;
      v.fmt = fmt; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.ferr = ferr; v.rerr = rerr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      in_format = v.fmt; in_opcode = v.opc; in_rd = v.rd; in_rs1 = v.rs1;
      in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_immediate = v.imm;
      cur_exp.instr = v.exp;
      cur_exp.err   = v.ferr | (RANGE_EN & v.rerr);
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send(input vec_t v, output int stalls);
      apply(v);
      in_valid = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (!in_ready && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Scoreboard: pop on transfer, push on acceptance (both happen at the next posedge)
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual=%h required=none", out_instruction);
            end else begin
               popped = q.pop_front();
               chk("out_instruction", out_instruction, popped.instr);
               chk("out_error", 32'(out_error), 32'(popped.err));
            end
         end
         if (in_valid && in_ready) q.push_back(cur_exp);
      end
   end

   initial begin
      int st, idx, acc;
      logic [31:0] snap;
      vec_t bp[3];

      //        fmt  opc    rd rs1 rs2 f3 f7     imm            expected       ferr rerr
      tbl[0]  = mk(F_I, 7'h13, 1, 2, 0, 0, 7'h00, 32'hFFFFFFFF, 32'hFFF10093, 0, 0);
      tbl[1]  = mk(F_B, 7'h63, 0, 1, 2, 0, 7'h00, 32'h00000008, 32'h00208463, 0, 0);
      tbl[2]  = mk(F_B, 7'h63, 0, 1, 2, 0, 7'h00, 32'h00000009, 32'h00208463, 0, 1);
      tbl[3]  = mk(F_J, 7'h6F, 1, 0, 0, 0, 7'h00, 32'h00000800, 32'h001000EF, 0, 0);
      tbl[4]  = mk(F_I, 7'h13, 0, 0, 0, 0, 7'h00, 32'h00000800, 32'h80000013, 0, 1);
      tbl[5]  = mk(F_I, 7'h13, 0, 0, 0, 0, 7'h00, 32'hFFFFF800, 32'h80000013, 0, 0);
      tbl[6]  = mk(F_R, 7'h33, 1, 2, 3, 0, 7'h20, 32'hDEADBEEF, 32'h403100B3, 0, 0);
      tbl[7]  = mk(F_S, 7'h23, 0, 1, 2, 2, 7'h55, 32'h00000008, 32'h0020A423, 0, 0);
      tbl[8]  = mk(F_S, 7'h23, 0, 0, 0, 0, 7'h00, 32'h000007FF, 32'h7E000FA3, 0, 0);
      tbl[9]  = mk(F_U, 7'h37, 5, 0, 0, 0, 7'h00, 32'h12345000, 32'h123452B7, 0, 0);
      tbl[10] = mk(F_U, 7'h37, 5, 0, 0, 0, 7'h00, 32'h12345001, 32'h123452B7, 0, 1);
      tbl[11] = mk(F_B, 7'h63, 0, 0, 0, 1, 7'h00, 32'hFFFFFFFC, 32'hFE001EE3, 0, 0);
      tbl[12] = mk(F_J, 7'h6F, 0, 0, 0, 0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F, 0, 0);
      tbl[13] = mk(F_J, 7'h6F, 0, 0, 0, 0, 7'h00, 32'h00100000, 32'h8000006F, 0, 1);
      tbl[14] = mk(6'b110000, 7'h13, 1, 2, 3, 0, 7'h00, 32'h0, 32'h00000000, 1, 0);
      tbl[15] = mk(6'b000000, 7'h33, 1, 2, 3, 0, 7'h00, 32'h0, 32'h00000000, 1, 0);
      tbl[16] = mk(F_I, 7'h13, 1, 2, 31, 0, 7'h7F, 32'h00000005, 32'h00510093, 0, 0);
      tbl[17] = mk(F_S, 7'h23, 0, 0, 0, 0, 7'h00, 32'hFFFFF7FF, 32'h7E000FA3, 0, 1);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instruction", out_instruction, 32'd0);
      chk("rst_out_error", 32'(out_error), 32'd0);
      chk("rst_err_sticky", 32'(err_sticky), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency: first word visible exactly two cycles after acceptance
      send(tbl[0], st);
      chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      drain();

      // Table, back-to-back with out_ready high: no stalls allowed
      foreach (tbl[i]) begin
         send(tbl[i], st);
         chk("throughput_stalls", 32'(st), 32'd0);
      end
      drain();

      // Backpressure: three offered, only two fit while out_ready is low
      bp[0] = tbl[6]; bp[1] = tbl[7]; bp[2] = tbl[9];
      out_ready = 1'b0; idx = 0; acc = 0; snap = '0;
      apply(bp[0]); in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 3) snap = out_instruction;
         if (in_ready) begin acc++; idx++; end
         @(posedge clk); #1;
         if (idx < 3) apply(bp[idx]); else in_valid = 1'b0;
      end
      chk("bp_accepted", 32'(acc), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_out_stable", out_instruction, snap);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && idx < 3; c++) begin
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk); #1;
         if (idx < 3) apply(bp[idx]); else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      drain();

      // Sticky error: set by earlier illegal formats, clearable, set wins over clear
      chk("sticky_after_table", 32'(err_sticky), 32'd1);
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      chk("sticky_cleared", 32'(err_sticky), 32'd0);
      send(tbl[14], st);
      @(posedge clk); #1;         // error word now at the output, transfers next edge
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      chk("sticky_set_wins", 32'(err_sticky), 32'd1);
      drain();

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      send(tbl[6], st);
      send(tbl[7], st);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_err_sticky", 32'(err_sticky), 32'd0);
      chk("async_rst_out_instruction", out_instruction, 32'd0);
      q.delete();
      @(negedge clk); rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send(tbl[16], st);
      chk("post_rst_cycle1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("post_rst_cycle2_valid", 32'(out_valid), 32'd1);
      drain();
      chk("post_rst_sticky", 32'(err_sticky), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
